sdram_fifo: RTL and testbench



---
 rtl/sdram_fifo_pkg.sv | 18 +
 rtl/sdram_fifo_if.sv | 28 ++
 rtl/sdram_fifo_ram.sv | 38 +++
 rtl/sdram_fifo.sv | 71 +++++++
 tb/tb_sdram_fifo.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/sdram_fifo_pkg.sv
// Shared types and defaults for the SDRAM-side word FIFO.
package sdram_fifo_pkg;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_DEPTH = 10;

    typedef enum logic [1:0] {
        OP_IDLE  = 2'b00,
        OP_RD    = 2'b01,
        OP_WR    = 2'b10,
        OP_WR_RD = 2'b11
    } fifo_op_e;

    function automatic int fifo_capacity(input int depth);
        return (1 << depth) - 1;
    endfunction

endpackage

// File: rtl/sdram_fifo_if.sv
// User/controller-facing FIFO port bundle.
interface sdram_fifo_if
    import sdram_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_WIDTH,
    parameter int DATA_DEPTH = DEF_DEPTH
);
    logic                  clr;
    logic                  wr_req;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  rd_req;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  full;
    logic                  empty;
    logic [DATA_DEPTH-1:0] wr_use_num;
    logic [DATA_DEPTH-1:0] rd_use_num;

    modport master (
        output clr, wr_req, wr_data, rd_req,
        input  rd_data, full, empty, wr_use_num, rd_use_num
    );

    modport slave (
        input  clr, wr_req, wr_data, rd_req,
        output rd_data, full, empty, wr_use_num, rd_use_num
    );

endinterface

// File: rtl/sdram_fifo_ram.sv
// Simple dual-port storage: one write port, one registered read port.
module sdram_fifo_ram
    import sdram_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_WIDTH,
    parameter int DATA_DEPTH = DEF_DEPTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,
    input  logic                  wr_en,
    input  logic [DATA_DEPTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [DATA_DEPTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem [0:(1<<DATA_DEPTH)-1];

    // Array left unreset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else if (clr) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/sdram_fifo.sv
// Single-clock word FIFO between user port and SDRAM burst engine.
module sdram_fifo
    import sdram_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_WIDTH,
    parameter int DATA_DEPTH = DEF_DEPTH
) (
    input  logic         clk,
    input  logic         rst_n,
    sdram_fifo_if.slave  bus
);

    localparam logic [DATA_DEPTH-1:0] PTR_ONE = DATA_DEPTH'(1);

    logic [DATA_DEPTH-1:0] wr_ptr;
    logic [DATA_DEPTH-1:0] rd_ptr;
    logic                  full;
    logic                  empty;
    logic                  wr_ok;
    logic                  rd_ok;
    fifo_op_e              op;

    // One slot stays free so full and empty are distinguishable.
    assign full  = ((wr_ptr + PTR_ONE) == rd_ptr);
    assign empty = (wr_ptr == rd_ptr);

    assign wr_ok = bus.wr_req && !full  && !bus.clr;
    assign rd_ok = bus.rd_req && !empty && !bus.clr;
    assign op    = fifo_op_e'({wr_ok, rd_ok});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (bus.clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            unique case (op)
                OP_WR:    wr_ptr <= wr_ptr + PTR_ONE;
                OP_RD:    rd_ptr <= rd_ptr + PTR_ONE;
                OP_WR_RD: begin
                    wr_ptr <= wr_ptr + PTR_ONE;
                    rd_ptr <= rd_ptr + PTR_ONE;
                end
                default:  ;
            endcase
        end
    end

    sdram_fifo_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DATA_DEPTH (DATA_DEPTH)
    ) u_ram (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (bus.clr),
        .wr_en   (wr_ok),
        .wr_addr (wr_ptr),
        .wr_data (bus.wr_data),
        .rd_en   (rd_ok),
        .rd_addr (rd_ptr),
        .rd_data (bus.rd_data)
    );

    assign bus.full       = full;
    assign bus.empty      = empty;
    assign bus.wr_use_num = wr_ptr - rd_ptr;
    assign bus.rd_use_num = wr_ptr - rd_ptr;

endmodule

// File: tb/tb_sdram_fifo.sv
// Scoreboard bench: small-depth FIFO directed tests plus a default-size smoke run.
module tb_sdram_fifo;
    import sdram_fifo_pkg::*;

    localparam int W   = 16;
    localparam int D   = 4;
    localparam int CAP = 15;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sdram_fifo_if #(.DATA_WIDTH(W), .DATA_DEPTH(D)) bus ();
    sdram_fifo_if #(.DATA_WIDTH(16), .DATA_DEPTH(10)) sbus ();

    sdram_fifo #(.DATA_WIDTH(W), .DATA_DEPTH(D)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    sdram_fifo dut_big (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (sbus)
    );

    int checks = 0;
    int passed = 0;
    logic [W-1:0] mdl   [$];
    logic [W-1:0] exp_q [$];
    logic acc;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] want);
        checks++;
        if (act === want) passed++;
        else $display("FAIL %s: got %0h want %0h", nm, act, want);
    endtask

    task automatic status(input string nm);
        chk({nm, "_use_w"}, 32'(bus.wr_use_num), mdl.size());
        chk({nm, "_use_r"}, 32'(bus.rd_use_num), mdl.size());
        chk({nm, "_empty"}, 32'(bus.empty), 32'(mdl.size() == 0));
        chk({nm, "_full"},  32'(bus.full),  32'(mdl.size() == CAP));
    endtask

    task automatic cyc(input logic wr, input logic [W-1:0] wd,
                       input logic rd, input logic c);
        bit was_full;
        bit was_empty;
        bus.wr_req  = wr;
        bus.wr_data = wd;
        bus.rd_req  = rd;
        bus.clr     = c;
        was_full  = (mdl.size() == CAP);
        was_empty = (mdl.size() == 0);
        if (c) begin
            mdl.delete();
        end else begin
            if (rd && !was_empty) exp_q.push_back(mdl.pop_front());
            if (wr && !was_full)  mdl.push_back(wd);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cyc(1'b0, '0, 1'b0, 1'b0);
    endtask

    task automatic scyc(input logic wr, input logic [15:0] wd,
                        input logic rd);
        sbus.wr_req  = wr;
        sbus.wr_data = wd;
        sbus.rd_req  = rd;
        @(posedge clk);
        #1;
    endtask

    // Monitor: a read accepted at an edge must show its word 1 cycle later.
    always begin
        @(negedge clk);
        acc = bus.rd_req && !bus.empty && !bus.clr && rst_n;
        @(posedge clk);
        #2;
        if (acc) begin
            if (exp_q.size() == 0) chk("rd_extra", exp_q.size(), 1);
            else chk("rd_data", 32'(bus.rd_data), 32'(exp_q.pop_front()));
        end
    end

    initial begin
        bus.clr = 0; bus.wr_req = 0; bus.wr_data = '0; bus.rd_req = 0;
        sbus.clr = 0; sbus.wr_req = 0; sbus.wr_data = '0; sbus.rd_req = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_empty", 32'(bus.empty), 1);
        chk("rst_full", 32'(bus.full), 0);
        chk("rst_use", 32'(bus.wr_use_num), 0);
        chk("rst_rd_data", 32'(bus.rd_data), 0);
        rst_n = 1'b1;
        idle();

        for (int i = 1; i <= 5; i++) cyc(1'b1, W'(i), 1'b0, 1'b0);
        status("wr5");
        for (int i = 0; i < 5; i++) begin
            cyc(1'b0, '0, 1'b1, 1'b0);
            status("rd5");
        end
        idle();
        chk("rd5_last", 32'(bus.rd_data), 32'h0005);

        cyc(1'b1, 16'h00AA, 1'b0, 1'b0);
        cyc(1'b1, 16'h00BB, 1'b0, 1'b0);
        cyc(1'b0, '0, 1'b1, 1'b0);
        idle();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_empty", 32'(bus.empty), 1);
        chk("arst_full", 32'(bus.full), 0);
        chk("arst_use", 32'(bus.rd_use_num), 0);
        chk("arst_rd_data", 32'(bus.rd_data), 0);
        mdl.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle();

        for (int i = 0; i < 16; i++) cyc(1'b1, W'(16'h0100 + i), 1'b0, 1'b0);
        status("fill16");
        chk("fill16_use", 32'(bus.wr_use_num), 15);
        cyc(1'b1, 16'h0999, 1'b1, 1'b0);
        status("full_both");
        for (int i = 0; i < 15; i++) cyc(1'b0, '0, 1'b1, 1'b0);
        idle();
        status("drain");

        for (int i = 0; i < 7; i++) cyc(1'b1, W'(16'h0200 + i), 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            cyc(1'b1, W'(16'h0300 + i), 1'b1, 1'b0);
            chk("wrap_use", 32'(bus.wr_use_num), 7);
        end
        for (int i = 0; i < 7; i++) cyc(1'b0, '0, 1'b1, 1'b0);
        idle();

        cyc(1'b1, 16'hABCD, 1'b0, 1'b0);
        cyc(1'b0, '0, 1'b1, 1'b0);
        idle();
        cyc(1'b0, '0, 1'b1, 1'b0);
        idle();
        chk("empty_rd_hold", 32'(bus.rd_data), 32'hABCD);
        status("empty_rd");
        cyc(1'b1, 16'h1234, 1'b1, 1'b0);
        chk("empty_both_use", 32'(bus.wr_use_num), 1);
        cyc(1'b0, '0, 1'b1, 1'b0);
        idle();

        for (int i = 0; i < 9; i++) cyc(1'b1, W'(16'h0400 + i), 1'b0, 1'b0);
        status("fill9");
        cyc(1'b1, 16'hDEAD, 1'b1, 1'b1);
        chk("clr_rd_data", 32'(bus.rd_data), 0);
        chk("clr_use", 32'(bus.wr_use_num), 0);
        status("clr");
        cyc(1'b1, 16'h5555, 1'b0, 1'b0);
        cyc(1'b0, '0, 1'b1, 1'b0);
        idle();
        chk("post_clr", 32'(bus.rd_data), 32'h5555);

        for (int i = 0; i < 3; i++) scyc(1'b1, 16'hC000 + 16'(i), 1'b0);
        chk("smoke_use", 32'(sbus.wr_use_num), 3);
        chk("smoke_full", 32'(sbus.full), 0);
        for (int i = 0; i < 3; i++) begin
            scyc(1'b0, '0, 1'b1);
            chk("smoke_rd", 32'(sbus.rd_data), 32'hC000 + i);
        end
        scyc(1'b0, '0, 1'b0);
        chk("smoke_empty", 32'(sbus.empty), 1);

        repeat (3) @(posedge clk);
        #3;
        chk("scoreboard_left", exp_q.size(), 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
